// File: rtl/instr_encode_loader.sv
// Assembles RV32I words from micro-op fields and streams them into imem; `INSTR_CHECK_EN adds a sticky err output.
// Latency: one cycle from accept to imem write; one word per two cycles.
// Backpressure: req_ready is low while writing, when full, in DONE, and whenever finish is asserted.
module instr_encode_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 256,
   parameter int BASE   = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [2:0]                   req_class,
   input  logic [2:0]                   req_funct3,
   input  logic                         req_alt,
   input  logic [4:0]                   req_rd,
   input  logic [4:0]                   req_rs1,
   input  logic [4:0]                   req_rs2,
   input  logic [12:0]                  req_imm,
   input  logic                         finish,
   input  logic                         restart,
   output logic                         imem_we,
   output logic [ADDR_W-1:0]            imem_addr,
   output logic [31:0]                  imem_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         cpu_run
`ifdef INSTR_CHECK_EN
   ,output logic                        err
`endif
);

   localparam int CW = $clog2(DEPTH+1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_REG    = 7'b0110011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

   logic [1:0]  state;
   logic [31:0] enc_word;
   logic [11:0] imm_i;
   logic        accept;

   // Shift-immediate forms carry the arithmetic select in bit 30, not the immediate.
   always_comb begin
      imm_i = req_imm[11:0];
      if (req_funct3 == 3'b101) begin
         imm_i = {1'b0, req_alt, 5'b0, req_imm[4:0]};
      end
      case (req_class)
         3'd0:    enc_word = {imm_i, req_rs1, req_funct3, req_rd, OP_IMM};
         3'd1:    enc_word = {1'b0, req_alt, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, OP_REG};
         3'd2:    enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], OP_STORE};
         3'd3:    enc_word = {req_imm[11:0], req_rs1, 3'b010, req_rd, OP_LOAD};
         3'd4:    enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                              req_imm[4:1], req_imm[11], OP_BRANCH};
         default: enc_word = NOP_WORD;
      endcase
   end

   assign full      = (count == CW'(DEPTH));
   assign req_ready = (state == S_IDLE) && !full && !finish;
   assign accept    = req_valid && req_ready;
   assign imem_we   = (state == S_WRITE);
   assign cpu_run   = (state == S_DONE);
   assign imem_addr = ADDR_W'(BASE) + ADDR_W'({count, 2'b00});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         imem_wdata <= 32'h0;
         count      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (finish) begin
                  state <= S_DONE;
               end else if (accept) begin
                  imem_wdata <= enc_word;
                  state      <= S_WRITE;
               end
            end
            S_WRITE: begin
               count <= count + CW'(1);
               state <= S_IDLE;
            end
            S_DONE: begin
               if (restart) begin
                  count <= '0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef INSTR_CHECK_EN
   logic req_bad;

   always_comb begin
      req_bad = 1'b0;
      if (req_class > 3'd4) begin
         req_bad = 1'b1;
      end else if (req_class == 3'd4) begin
         req_bad = (req_funct3 == 3'b010) || (req_funct3 == 3'b011) || req_imm[0];
      end else if (req_class != 3'd1) begin
         req_bad = (req_imm[12] != req_imm[11]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (state == S_DONE && restart) begin
         err <= 1'b0;
      end else if (accept && req_bad) begin
         err <= 1'b1;
      end
   end
`endif

endmodule
